// File: rtl/pulse_meas.sv
// Pulse train measurement: per-period length and HIGH time, with a no-edge timeout.
// Define PULSE_MEAS_SYNC_EN to pass pulse_in through a 2-flop synchronizer.
//
// state | meaning
// IDLE  | waiting for the first rising edge; no measurement in progress
// RUN   | counting cycles since the last rising edge
module pulse_meas #(
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  pulse_in,
  input  logic [CNTR_WIDTH-1:0] timeout_max,
  output logic [CNTR_WIDTH-1:0] period_out,
  output logic [CNTR_WIDTH-1:0] high_out,
  output logic                  meas_valid,
  output logic                  timeout,
  output logic                  level_out,
  output logic                  busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  state_t                state;
  logic                  s;
  logic                  s_d1;
  logic                  rise;
  logic [CNTR_WIDTH-1:0] lim;
  logic [CNTR_WIDTH-1:0] period_cnt;
  logic [CNTR_WIDTH-1:0] high_cnt;

`ifdef PULSE_MEAS_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nrst) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], pulse_in};
  end

  assign s = sync_q[1];
`else
  assign s = pulse_in;
`endif

  // Edge history runs even while disabled so re-enabling never sees a stale level.
  always_ff @(posedge clk) begin
    if (!nrst) s_d1 <= 1'b0;
    else       s_d1 <= s;
  end

  assign rise = s & ~s_d1;
  assign lim  = (timeout_max == '0) ? '1 : timeout_max;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      level_out  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (!en) begin
        state      <= IDLE;
        busy       <= 1'b0;
        period_cnt <= '0;
        high_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              period_cnt <= CNT_ONE;
              high_cnt   <= CNT_ONE;
              state      <= RUN;
              busy       <= 1'b1;
            end
          end
          RUN: begin
            // An edge landing on the limit still counts as a valid period.
            if (rise) begin
              period_out <= period_cnt;
              high_out   <= high_cnt;
              meas_valid <= 1'b1;
              period_cnt <= CNT_ONE;
              high_cnt   <= CNT_ONE;
            end else if (period_cnt >= lim) begin
              timeout   <= 1'b1;
              level_out <= s;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              period_cnt <= period_cnt + CNT_ONE;
              high_cnt   <= high_cnt + CNTR_WIDTH'(s);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
